// File: rtl/prm_edge_check_sched.sv
// Streams obstacle codes through an external PRM edge-check bank and OR-accumulates
// the per-code blocked-edge masks into one result returned over a valid/ready handshake.
module prm_edge_check_sched #(
  parameter int CODE_W   = 15,
  parameter int NUM_EDGE = 64,
  parameter int CHK_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                code_valid,
  input  logic [CODE_W-1:0]   code_data,
  input  logic                code_last,
  output logic                code_ready,
  output logic [CODE_W-1:0]   chk_code,
  input  logic [NUM_EDGE-1:0] chk_mask,
  output logic                mask_valid,
  output logic [NUM_EDGE-1:0] mask_data,
  input  logic                mask_ready,
  output logic [CNT_W-1:0]    code_count,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_nx;
  logic [CHK_LAT:1]    vld_pipe, last_pipe;
  logic [NUM_EDGE-1:0] acc;
  logic                hs, tag_out, last_out;

  assign code_ready = (state == RUN);
  assign busy       = (state != IDLE);
  assign hs         = code_valid & code_ready & ~abort;
  // Tag index k means "accepted k edges ago"; the bank result is valid when k == CHK_LAT.
  assign tag_out    = vld_pipe[CHK_LAT];
  assign last_out   = tag_out & last_pipe[CHK_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = RUN;
        RUN:     if (hs && code_last) state_nx = DRAIN;
        DRAIN:   if (last_out) state_nx = DONE;
        DONE:    if (mask_valid && mask_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      last_pipe  <= '0;
      acc        <= '0;
      chk_code   <= '0;
      code_count <= '0;
      mask_valid <= 1'b0;
      mask_data  <= '0;
    end else if (abort) begin
      vld_pipe   <= '0;
      last_pipe  <= '0;
      mask_valid <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        acc        <= '0;
        code_count <= '0;
      end
      if (hs) begin
        chk_code <= code_data;
        if (code_count != '1) code_count <= code_count + CNT_W'(1);
      end
      for (int k = CHK_LAT; k > 1; k--) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end
      vld_pipe[1]  <= hs;
      last_pipe[1] <= hs & code_last;
      if (tag_out) acc <= acc | chk_mask;
      // Result is published one edge after the final OR so mask_data is a clean copy.
      if (state == DONE) begin
        if (!mask_valid) begin
          mask_valid <= 1'b1;
          mask_data  <= acc;
        end else if (mask_ready) begin
          mask_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prm_edge_check_sched.sv
// Drives a CHK_LAT=1 and a CHK_LAT=3 instance with identical stimulus and checks both
// against a transaction-level model plus hand-computed expectations.
module tb_prm_edge_check_sched;
  localparam int CW = 15, NE = 64, NW = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 0, abort = 0, code_valid = 0, code_last = 0, mask_ready = 0;
  logic [CW-1:0] code_data = '0;
  logic bank_zero = 0;

  logic [1:0]          code_ready, mask_valid, busy;
  logic [1:0][CW-1:0]  chk_code;
  logic [1:0][NE-1:0]  chk_mask, mask_data;
  logic [1:0][NW-1:0]  code_count;

  prm_edge_check_sched #(.CODE_W(CW), .NUM_EDGE(NE), .CHK_LAT(1), .CNT_W(NW)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .code_valid(code_valid),
    .code_data(code_data), .code_last(code_last), .code_ready(code_ready[0]),
    .chk_code(chk_code[0]), .chk_mask(chk_mask[0]), .mask_valid(mask_valid[0]),
    .mask_data(mask_data[0]), .mask_ready(mask_ready), .code_count(code_count[0]),
    .busy(busy[0]));

  prm_edge_check_sched #(.CODE_W(CW), .NUM_EDGE(NE), .CHK_LAT(3), .CNT_W(NW)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .code_valid(code_valid),
    .code_data(code_data), .code_last(code_last), .code_ready(code_ready[1]),
    .chk_code(chk_code[1]), .chk_mask(chk_mask[1]), .mask_valid(mask_valid[1]),
    .mask_data(mask_data[1]), .mask_ready(mask_ready), .code_count(code_count[1]),
    .busy(busy[1]));

  // Check bank: a few fixed responses, otherwise a deterministic hash of the code.
  function automatic logic [NE-1:0] bank(input logic [CW-1:0] c);
    logic [33:0] lo;
    case (c)
      15'h0001: return 64'h1;
      15'h4200: return 64'h10;
      15'h7FFF: return 64'h0;
      default:  ;
    endcase
    lo = 34'(c) << c[3:0];
    return {c, c ^ 15'h5555, lo};
  endfunction

  // The 3-cycle instance sees a bank pipelined to match its sampling point.
  logic [1:0][CW-1:0] h3;
  always @(posedge clk) begin
    h3[0] <= chk_code[1];
    h3[1] <= h3[0];
  end
  assign chk_mask[0] = bank_zero ? '0 : bank(chk_code[0]);
  assign chk_mask[1] = bank_zero ? '0 : bank(h3[1]);

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: result is the OR of bank responses of all accepted codes,
  // published lat+1 edges after the last accept.
  logic [1:0]          m_busy, m_run, m_mv;
  logic [1:0][NE-1:0]  m_acc, m_md;
  logic [1:0][NW-1:0]  m_cnt;
  logic [1:0][CW-1:0]  m_chk;
  int m_dead [2];
  int m_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '0; m_run <= '0; m_mv <= '0;
      m_acc <= '0; m_md <= '0; m_cnt <= '0; m_chk <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (abort) begin
          m_busy[i] <= 1'b0; m_run[i] <= 1'b0; m_mv[i] <= 1'b0;
        end else if (!m_busy[i]) begin
          if (start) begin
            m_busy[i] <= 1'b1; m_run[i] <= 1'b1; m_cnt[i] <= '0; m_acc[i] <= '0;
          end
        end else if (m_run[i]) begin
          if (code_valid) begin
            m_chk[i] <= code_data;
            if (m_cnt[i] != '1) m_cnt[i] <= m_cnt[i] + 16'd1;
            m_acc[i] <= m_acc[i] | (bank_zero ? 64'h0 : bank(code_data));
            if (code_last) begin
              m_run[i]  <= 1'b0;
              m_dead[i] <= m_cyc + (i == 1 ? 3 : 1) + 1;
            end
          end
        end else if (m_mv[i]) begin
          if (mask_ready) begin m_mv[i] <= 1'b0; m_busy[i] <= 1'b0; end
        end else if (m_cyc == m_dead[i]) begin
          m_mv[i] <= 1'b1; m_md[i] <= m_acc[i];
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("code_ready[%0d]", i), 64'(code_ready[i]), 64'(m_run[i]));
        chk($sformatf("busy[%0d]", i),       64'(busy[i]),       64'(m_busy[i]));
        chk($sformatf("mask_valid[%0d]", i), 64'(mask_valid[i]), 64'(m_mv[i]));
        chk($sformatf("mask_data[%0d]", i),  mask_data[i],       m_md[i]);
        chk($sformatf("code_count[%0d]", i), 64'(code_count[i]), 64'(m_cnt[i]));
        chk($sformatf("chk_code[%0d]", i),   64'(chk_code[i]),   64'(m_chk[i]));
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rise [2];
  logic [1:0] mv_q = '0;
  always @(posedge clk) begin
    #1;
    for (int j = 0; j < 2; j++) begin
      if (mask_valid[j] && !mv_q[j]) rise[j] = cyc;
      mv_q[j] = mask_valid[j];
    end
  end

  logic [CW-1:0] codes [8];
  int t_last = 0;

  task automatic begin_pass();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    rise[0] = -1; rise[1] = -1;
  endtask

  task automatic send_burst(input int n);
    for (int k = 0; k < n; k++) begin
      code_valid = 1; code_data = codes[k]; code_last = (k == n - 1);
      @(posedge clk); #1;
      if (k == n - 1) t_last = cyc;
      @(negedge clk);
    end
    code_valid = 0; code_last = 0;
  endtask

  task automatic finish_pass(input int hold);
    for (int w = 0; w < 20 && mask_valid != 2'b11; w++) @(negedge clk);
    chk("both_valid", 64'(mask_valid), 64'h3);
    chk("lat1_delay", 64'(rise[0] - t_last), 64'd2);
    chk("lat3_delay", 64'(rise[1] - t_last), 64'd4);
    repeat (hold) @(negedge clk);
    chk("valid_held", 64'(mask_valid), 64'h3);
    mask_ready = 1;
    @(negedge clk); mask_ready = 0;
    chk("idle_after_take", 64'(busy), 64'h0);
    chk("valid_dropped", 64'(mask_valid), 64'h0);
  endtask

  initial begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_code_ready", 64'(code_ready[i]), 64'h0);
      chk("rst_mask_valid", 64'(mask_valid[i]), 64'h0);
      chk("rst_mask_data", mask_data[i], 64'h0);
      chk("rst_busy", 64'(busy[i]), 64'h0);
      chk("rst_count", 64'(code_count[i]), 64'h0);
      chk("rst_chk_code", 64'(chk_code[i]), 64'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;

    // three-code pass with fixed bank responses
    codes[0] = 15'h0001; codes[1] = 15'h4200; codes[2] = 15'h7FFF;
    begin_pass(); send_burst(3); finish_pass(0);
    chk("t1_mask", mask_data[0], 64'h11);
    chk("t1_mask_lat3", mask_data[1], 64'h11);
    chk("t1_count", 64'(code_count[0]), 64'd3);
    chk("t1_model_mask", m_md[0], 64'h11);

    // abort after the 2nd accept, with a competing handshake
    begin_pass();
    code_valid = 1; code_data = 15'h0100;
    @(negedge clk); code_data = 15'h0200;
    @(negedge clk); abort = 1; code_data = 15'h0300;
    @(negedge clk); abort = 0; code_valid = 0;
    chk("ab_ready", 64'(code_ready), 64'h0);
    chk("ab_busy", 64'(busy), 64'h0);
    chk("ab_count", 64'(code_count[0]), 64'd2);
    chk("ab_mask_kept", mask_data[0], 64'h11);
    repeat (4) @(negedge clk);
    chk("ab_no_valid", 64'(mask_valid), 64'h0);

    // toggling valid; the IDLE offer must be ignored, one code in the pass
    @(negedge clk); start = 1; code_valid = 1; code_data = 15'h3333;
    @(negedge clk); start = 0; code_valid = 0; rise[0] = -1; rise[1] = -1;
    @(negedge clk); code_valid = 1; code_data = 15'h2A5A; code_last = 1;
    @(posedge clk); #1; t_last = cyc;
    @(negedge clk); code_valid = 0; code_last = 0;
    finish_pass(0);
    chk("tg_count", 64'(code_count[0]), 64'd1);
    chk("tg_chk_code", 64'(chk_code[0]), 64'h2A5A);
    chk("tg_mask", mask_data[0], {15'h2A5A, 15'h7F0F, 34'hA96800});

    // back-to-back 5 codes, consumer stalls 4 cycles
    codes[0] = 15'h0100; codes[1] = 15'h0203; codes[2] = 15'h1234;
    codes[3] = 15'h0F0F; codes[4] = 15'h7001;
    begin_pass(); send_burst(5); finish_pass(4);
    chk("bb_count", 64'(code_count[1]), 64'd5);

    // 4-code pass, both latencies
    codes[0] = 15'h0003; codes[1] = 15'h0040; codes[2] = 15'h0500; codes[3] = 15'h6000;
    begin_pass(); send_burst(4); finish_pass(1);
    chk("q4_count", 64'(code_count[1]), 64'd4);

    // asynchronous reset while draining
    codes[0] = 15'h0001; codes[1] = 15'h4200;
    begin_pass(); send_burst(2);
    #2 rst_n = 0;
    #1;
    chk("ar_busy", 64'(busy), 64'h0);
    chk("ar_ready", 64'(code_ready), 64'h0);
    chk("ar_valid", 64'(mask_valid), 64'h0);
    chk("ar_mask0", mask_data[0], 64'h0);
    chk("ar_mask1", mask_data[1], 64'h0);
    chk("ar_count", 64'(code_count[0]), 64'h0);
    chk("ar_chk_code", 64'(chk_code[1]), 64'h0);
    @(negedge clk); rst_n = 1; bank_zero = 1;
    codes[0] = 15'h1111; codes[1] = 15'h2222;
    begin_pass(); send_burst(2); finish_pass(0);
    chk("zb_mask0", mask_data[0], 64'h0);
    chk("zb_mask1", mask_data[1], 64'h0);
    chk("zb_count", 64'(code_count[0]), 64'd2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d exp %0d", cyc, 0);
    $fatal(1);
  end
endmodule

// File: doc/prm_edge_check_sched.md
Name: prm_edge_check_sched

Overview:
- Sequencer that streams 15-bit obstacle/voxel codes through an external bank of combinational PRM edge-check blocks, one bit of `chk_mask` per roadmap edge.
- OR-accumulates the per-code `chk_mask` into a blocked-edge mask and returns it with a valid/ready handshake.
- Sits between the occupancy-code source and the roadmap planner.

Parameters:
- CODE_W, 15, width of one obstacle code (inputs A..O of a check block).
- NUM_EDGE, 64, number of edge-check blocks (width of `chk_mask` / `mask_data`).
- CHK_LAT, 1, edges from `chk_code` update to `chk_mask` sample; legal range 1..4.
- CNT_W, 16, width of `code_count`.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle request to begin a pass; honoured only in IDLE.
- abort, in, 1, synchronous; discards the pass and returns to IDLE.
- code_valid, in, 1, a code is offered.
- code_data, in, CODE_W, obstacle code.
- code_last, in, 1, qualifies the final code of a pass.
- code_ready, out, 1, block accepts a code this cycle.
- chk_code, out, CODE_W, registered code driving the check bank.
- chk_mask, in, NUM_EDGE, check-bank result (1 = edge blocked).
- mask_valid, out, 1, result available.
- mask_data, out, NUM_EDGE, accumulated blocked-edge mask.
- mask_ready, in, 1, consumer takes the result.
- code_count, out, CNT_W, codes accepted in the current/last pass; saturating.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; code_ready=0, chk_code=0, mask_valid=0, mask_data=0, code_count=0, busy=0, accumulator=0, pipeline tags cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - code_ready=0.
  - start=1 -> accumulator=0, code_count=0, go RUN.
  - mask_data holds the last result until start.
- RUN:
  - code_ready=1.
  - Handshake at edge t (code_valid & code_ready): chk_code <= code_data; code_count increments (saturates at 2^CNT_W-1); tag {valid, last} enters a CHK_LAT-deep shift register.
  - When a tag exits at edge t+CHK_LAT: accumulator |= chk_mask.
  - A handshake with code_last=1 -> go DRAIN; code_ready drops the next cycle, so no code is accepted after last.
- DRAIN:
  - code_ready=0.
  - Exits to DONE on the edge where the last tag exits and its chk_mask is OR-ed in.
- DONE:
  - mask_valid=1, mask_data=accumulator, stable while mask_ready=0.
  - mask_valid & mask_ready -> IDLE; mask_valid=0 the next cycle.
- Latency: for CHK_LAT=1, last handshake at edge t gives mask_valid=1 after edge t+2.
- chk_code holds its value between accepts; no bubble codes are presented.
- Back-to-back accepts are allowed every cycle (one code/cycle throughput).
- abort: any state -> IDLE next edge.
  - Pipeline tags cleared, code_ready=0, mask_valid=0.
  - Accumulator is not copied to mask_data; code_count keeps the partial value.
  - abort has priority over start and over the handshake in the same cycle.
- start outside IDLE is ignored. start and abort in the same IDLE cycle -> stay IDLE.
- Simultaneous mask handshake and start in DONE: start is ignored; IDLE is entered first.
- Reset mid-pass: immediate return to reset values; no partial result.
- Accumulator all-ones: codes are still accepted and counted until last (no early exit).

Test Plan:
- CHK_LAT=1, start, 3 codes 0x0001/0x4200/0x7FFF (last on third), bank returns mask 0x1, 0x10, 0x0 -> mask_data=0x11, code_count=3, mask_valid two edges after the last accept.
- Back-to-back 5-code pass with mask_ready held low 4 cycles -> mask_valid and mask_data stable throughout; IDLE one cycle after mask_ready=1.
- abort asserted the cycle after the 2nd accept of a 4-code pass -> code_ready=0 next cycle, mask_valid never rises, mask_data keeps its previous value 0x11.
- code_valid toggling 1/0 with a single code_last code 0x2A5A -> code_count=1, chk_code=0x2A5A, mask_data equals the bank response for 0x2A5A.
- CHK_LAT=3, 4 codes -> mask_valid exactly 4 edges after the last accept; all 4 responses OR-ed in.
- Assert rst_n low in DRAIN -> all outputs return to zero asynchronously; start after release -> normal pass with mask_data=0 when the bank returns all zeros.
